deco_frame_if: RTL

//  Parametrised host-side framing shell in front of the turbo decoder core.
//  - Collects NUM_BEATS beats of BEAT_W bits (start_i-qualified) into one frame.
//  - Ping-pong buffers frames so the host can load frame N+1 while the core holds frame N.
//  - Forwards frames to the core over a valid/ready handshake.
//  - Queues core results in a FIFO and returns them as data_o / done_o with optional host backpressure.

---
 rtl/deco_pkg.sv | 21 ++
 rtl/deco_res_fifo.sv | 63 ++++++
 rtl/deco_frame_if.sv | 133 +++++++++++++
 3 files changed

// File: rtl/deco_pkg.sv
// Shared types and constant helpers for the turbo decoder host framing shell.
package deco_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_WAIT = 2'd2
   } coll_state_t;

   function automatic int frmWidth(input int beatW, input int numBeats);
      return beatW * numBeats;
   endfunction

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/deco_res_fifo.sv
// Result FIFO between the decoder core and the host, with a registered output
// stage that holds data_o/done_o while the host applies backpressure.
module deco_res_fifo
   import deco_pkg::*;
#(
   parameter int OUT_W     = 5,
   parameter int RES_DEPTH = 4
) (
   input  logic             i_clk,
   input  logic             i_rstN,
   input  logic             i_valid,
   input  logic [OUT_W-1:0] i_data,
   output logic             o_ready,
   input  logic             i_outReady,
   output logic [OUT_W-1:0] o_data,
   output logic             o_done
);

   localparam int AW = clog2(RES_DEPTH);

   logic [AW:0]      r_wrPtr;
   logic [AW:0]      r_rdPtr;
   logic [OUT_W-1:0] r_mem [RES_DEPTH];
   logic [OUT_W-1:0] r_data;
   logic             r_done;
   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign w_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
   assign w_empty = (r_wrPtr == r_rdPtr);
   assign w_push  = i_valid && !w_full;
   assign w_pop   = !w_empty && (i_outReady || !r_done);

   assign o_ready = !w_full;
   assign o_data  = r_data;
   assign o_done  = r_done;

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wrPtr[AW-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
            r_data  <= r_mem[r_rdPtr[AW-1:0]];
            r_done  <= 1'b1;
         end else if (i_outReady) begin
            r_done  <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/deco_frame_if.sv
// Host-side framing shell: collects beats into frames, ping-pong buffers them
// toward the decoder core and returns core results through a FIFO.
module deco_frame_if
   import deco_pkg::*;
#(
   parameter int BEAT_W    = 21,
   parameter int NUM_BEATS = 4,
   parameter int OUT_W     = 5,
   parameter int RES_DEPTH = 4,
   localparam int FRM_W    = frmWidth(BEAT_W, NUM_BEATS)
) (
   input  logic              clk_p_i,
   input  logic              reset_n_i,
   input  logic              start_i,
   input  logic [BEAT_W-1:0] data_i,
   output logic              busy_o,
   output logic              frm_valid_o,
   output logic [FRM_W-1:0]  frm_data_o,
   input  logic              frm_ready_i,
   input  logic              res_valid_i,
   input  logic [OUT_W-1:0]  res_data_i,
   output logic              res_ready_o,
   input  logic              out_ready_i,
   output logic [OUT_W-1:0]  data_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int CNT_W = clog2(NUM_BEATS + 1);

   coll_state_t      r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic             r_wrPtr;
   logic             r_rdPtr;
   logic [1:0]       r_count;
   logic             r_busy;
   logic [FRM_W-1:0] r_buf [2];

   logic [CNT_W-1:0] w_beatIdx;
   logic             w_capture;
   logic             w_fill;
   logic             w_xfer;
   logic [1:0]       w_countNext;

   // A beat is written straight into the free buffer; the last beat marks it full.
   always_comb begin
      w_beatIdx   = (r_state == ST_LOAD) ? r_cnt : '0;
      w_capture   = start_i && (((r_state == ST_IDLE) && !r_busy) || (r_state == ST_LOAD));
      w_fill      = w_capture && (w_beatIdx == CNT_W'(NUM_BEATS - 1));
      w_xfer      = (r_count != 2'd0) && frm_ready_i;
      w_countNext = r_count;
      if (w_fill && !w_xfer)      w_countNext = r_count + 2'd1;
      else if (!w_fill && w_xfer) w_countNext = r_count - 2'd1;
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start_i) begin
                  if (!r_busy) begin
                     r_cnt   <= CNT_W'(1);
                     r_state <= w_fill ? ST_WAIT : ST_LOAD;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= ST_WAIT;
                  end
               end
            end
            ST_LOAD: begin
               if (start_i) begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_fill) r_state <= ST_WAIT;
               end else begin
                  r_err   <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (!start_i) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_p_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wrPtr <= 1'b0;
         r_rdPtr <= 1'b0;
         r_count <= 2'd0;
         r_busy  <= 1'b0;
         r_buf[0] <= '0;
         r_buf[1] <= '0;
      end else begin
         if (w_capture) begin
            for (int k = 0; k < NUM_BEATS; k++) begin
               if (w_beatIdx == CNT_W'(k)) r_buf[r_wrPtr][k*BEAT_W +: BEAT_W] <= data_i;
            end
         end
         if (w_fill) r_wrPtr <= ~r_wrPtr;
         if (w_xfer) r_rdPtr <= ~r_rdPtr;
         r_count <= w_countNext;
         r_busy  <= (w_countNext == 2'd2);
      end
   end

   assign busy_o      = r_busy;
   assign frm_valid_o = (r_count != 2'd0);
   assign frm_data_o  = r_buf[r_rdPtr];
   assign err_o       = r_err;

   deco_res_fifo #(
      .OUT_W     (OUT_W),
      .RES_DEPTH (RES_DEPTH)
   ) u_resFifo (
      .i_clk      (clk_p_i),
      .i_rstN     (reset_n_i),
      .i_valid    (res_valid_i),
      .i_data     (res_data_i),
      .o_ready    (res_ready_o),
      .i_outReady (out_ready_i),
      .o_data     (data_o),
      .o_done     (done_o)
   );

endmodule
